inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- PC generator and fetch stage directly upstream of the InstructionCache BRAM.
- Drives the cache port-A word address each cycle and consumes the synchronous read data, which arrives one cycle later.
- Presents {instruction, PC} to decode with a valid/ready handshake.
- Handles the BRAM's 1-cycle read latency under decode back-pressure (one-entry hold buffer) and branch/jump redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
icache_addr  output  30  word address [31:2] to InstructionCache addra
icache_rdata  input  32  InstructionCache douta; data for the address presented the previous cycle
redirect_valid  input  1  EX redirect (taken branch/jal/jalr/flush)
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0
id_ready  input  1  decode accepts this cycle
id_valid  output  1  instruction/PC valid to decode
id_inst  output  32  instruction to decode
id_pc  output  32  byte PC of id_inst

Behaviour:
- State: fetch_pc[31:0] (address being presented), rsp_valid/rsp_pc (address presented last cycle, its data on icache_rdata now), hold_valid/hold_inst/hold_pc.
- Reset (async, rst_n=0): fetch_pc=RESET_PC, rsp_valid=0, hold_valid=0, rsp_pc=0, hold_inst=0, hold_pc=0. Outputs: id_valid=0, icache_addr=RESET_PC[31:2].
- Combinational outputs:
  - icache_addr=fetch_pc[31:2].
  - id_valid=(hold_valid|rsp_valid)&~redirect_valid.
  - id_inst/id_pc = hold_valid ? hold_inst/hold_pc : icache_rdata/rsp_pc.
- stall = (hold_valid|rsp_valid) & ~id_ready. advance = ~stall.
- Normal cycle (no redirect):
  - rsp_valid<=1, rsp_pc<=fetch_pc.
  - If advance: fetch_pc<=fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - If stall & ~hold_valid: hold_valid<=1, hold_inst<=icache_rdata, hold_pc<=rsp_pc. fetch_pc is held, so the BRAM rereads it.
  - If hold_valid & id_ready: hold_valid<=0. Data for rsp_pc (==fetch_pc) is re-presented next cycle; nothing is lost or duplicated.
- Latency: first id_valid 2 cycles after rst_n deasserts (1 cycle address, 1 cycle BRAM). Steady state: 1 instruction/cycle while id_ready=1.
- Redirect (priority over everything, including stall):
  - fetch_pc<={redirect_pc[31:2],2'b00}, rsp_valid<=0, hold_valid<=0 (wrong-path data discarded).
  - id_valid forced 0 that cycle.
  - Target instruction valid 2 cycles after the redirect cycle.
- Out-of-range addresses: the cache returns 32'h0. It is passed through as a valid instruction; no trap generated here.
- Reset mid-operation: all in-flight and held data dropped immediately; restart at RESET_PC.

Optional Feature:
- Macro FETCH_REDIRECT_BYPASS_EN.
- Defined:
  - icache_addr = redirect_valid ? redirect_pc[31:2] : fetch_pc[31:2].
  - On redirect: fetch_pc<=target+4, rsp_valid<=1, rsp_pc<=target, hold_valid<=0.
  - Redirect penalty drops to 1 cycle; target instruction valid the cycle after redirect. Adds a combinational path redirect_pc->icache_addr.
- Undefined: behaviour as above; 2-cycle penalty; icache_addr purely registered.

Test Plan:
Bench instantiates InstructionCache loaded with the MatMul image (word0=32'h00404713, word1=32'h00404693, word2=32'h00e696b3, word3=32'h00004633).
- Reset then release, id_ready=1 -> cycle 2: id_valid=1, id_pc=0, id_inst=32'h00404713; then pc 4/8/12 with 32'h00404693/32'h00e696b3/32'h00004633 on consecutive cycles.
- id_ready=0 for 3 cycles while id_pc=4 is presented -> id_inst holds 32'h00404693, pc 4 for all 3 cycles; after release, pc 8 then 12 follow with no skip or duplicate.
- redirect_valid=1, redirect_pc=32'h0000_0008 while id_pc=0x10 -> id_valid=0 that cycle and next; pc 8 (32'h00e696b3) appears 2 cycles after redirect; with FETCH_REDIRECT_BYPASS_EN it appears 1 cycle after.
- Redirect coincident with stall (hold_valid=1) -> held instruction dropped; next valid is the target.
- redirect_pc=32'h0000_FFFE -> fetch from 32'h0000_FFFC (outside cache) -> id_inst=32'h0; next pc 32'h0001_0000.
- rst_n asserted mid-stream during a stall -> id_valid=0 immediately (async); after release, restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_if
//  Purpose  : Bundles the fetch unit's three connections: the InstructionCache
//             port-A read path, the EX redirect request and the decode
//             valid/ready handshake.
//  Modports : master - fetch unit side (drives cache address and decode data)
//             slave  - environment side (cache, EX stage and decode)
//  Signals  : icache_addr[29:0]  word address [31:2] to cache addra
//             icache_rdata[31:0] cache douta, data for last cycle's address
//             redirect_valid     EX redirect request
//             redirect_pc[31:0]  redirect target (bits [1:0] ignored)
//             id_ready           decode accepts this cycle
//             id_valid           instruction/PC valid to decode
//             id_inst[31:0]      instruction to decode
//             id_pc[31:0]        byte PC of id_inst
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output icache_addr,
    output id_valid,
    output id_inst,
    output id_pc,
    input  icache_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready
  );

  modport slave (
    input  icache_addr,
    input  id_valid,
    input  id_inst,
    input  id_pc,
    output icache_rdata,
    output redirect_valid,
    output redirect_pc,
    output id_ready
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : PC generator and fetch stage in front of the InstructionCache
//             BRAM. Presents a word address each cycle, consumes the read
//             data one cycle later and hands {instruction, PC} to decode with
//             a valid/ready handshake. A one-entry hold buffer absorbs the
//             BRAM latency under decode back-pressure; EX redirects override
//             everything and discard wrong-path data.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - inst_fetch_unit_if.master (cache, redirect, decode)
//  Params   : RESET_PC - fetch address after reset, bits [1:0] must be 0
//  Macros   : FETCH_REDIRECT_BYPASS_EN - when defined the redirect target is
//             steered straight onto icache_addr in the redirect cycle, cutting
//             the redirect penalty from 2 cycles to 1 at the cost of a
//             combinational redirect_pc -> icache_addr path.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire               clk,
  input  wire               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam logic [31:0] c_pc_step = 32'd4;

  // Address presented to the cache this cycle.
  logic [31:0] r_fetch_pc;
  // Address presented last cycle; its data is on icache_rdata now.
  logic        r_rsp_valid;
  logic [31:0] r_rsp_pc;
  // One-entry buffer capturing the response decode could not take.
  logic        r_hold_valid;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_pc;

  logic [31:0] w_redirect_target;
  logic        w_stall;
  logic        w_advance;
  logic        w_unused_ok;

  assign w_redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_ok       = &{1'b0, bus.redirect_pc[1:0]};

  assign w_stall   = (r_hold_valid | r_rsp_valid) & ~bus.id_ready;
  assign w_advance = ~w_stall;

`ifdef FETCH_REDIRECT_BYPASS_EN
  assign bus.icache_addr = bus.redirect_valid ? bus.redirect_pc[31:2]
                                              : r_fetch_pc[31:2];
`else
  assign bus.icache_addr = r_fetch_pc[31:2];
`endif

  // The held entry is always older than the live BRAM response, so it wins.
  assign bus.id_valid = (r_hold_valid | r_rsp_valid) & ~bus.redirect_valid;
  assign bus.id_inst  = r_hold_valid ? r_hold_inst : bus.icache_rdata;
  assign bus.id_pc    = r_hold_valid ? r_hold_pc   : r_rsp_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_rsp_valid  <= 1'b0;
      r_rsp_pc     <= 32'h0;
      r_hold_valid <= 1'b0;
      r_hold_inst  <= 32'h0;
      r_hold_pc    <= 32'h0;
    end else if (bus.redirect_valid) begin
      r_hold_valid <= 1'b0;
`ifdef FETCH_REDIRECT_BYPASS_EN
      // The target was already presented to the cache this cycle.
      r_fetch_pc  <= w_redirect_target + c_pc_step;
      r_rsp_valid <= 1'b1;
      r_rsp_pc    <= w_redirect_target;
`else
      r_fetch_pc  <= w_redirect_target;
      r_rsp_valid <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b1;
      r_rsp_pc    <= r_fetch_pc;
      if (w_advance) begin
        r_fetch_pc <= r_fetch_pc + c_pc_step;
      end
      // On the first stalled cycle the live response is parked; fetch_pc is
      // held so the BRAM re-reads the next address and rsp_pc tracks it, so
      // the slot after the held entry is already correct when it drains.
      if (w_stall && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_inst  <= bus.icache_rdata;
        r_hold_pc    <= r_rsp_pc;
      end else if (r_hold_valid && bus.id_ready) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
